// File: rtl/sobel_frame_sequencer.sv
// sobel_frame_sequencer: buffers single-cycle pixel strobes from the SPI
// receive path in a small FIFO and issues them to the Sobel core through a
// valid/ready issue register. It tracks column/row position, marks line ends,
// pulses frame start/done, and (when SOBEL_SEQ_FLUSH_EN is defined) appends
// FLUSH_PX zero pixels after each frame to drain the 3x3 window.
// Without SOBEL_SEQ_FLUSH_EN the frame ends right after its last pixel.
module sobel_frame_sequencer #(
  parameter int MAX_PIXEL_BITS = 24,
  parameter int IMG_WIDTH      = 16,
  parameter int IMG_HEIGHT     = 16,
  parameter int FIFO_DEPTH     = 4,
  parameter int FLUSH_PX       = IMG_WIDTH + 1
) (
  input  logic                            clk_i,
  input  logic                            nreset_i,
  input  logic [MAX_PIXEL_BITS-1:0]       in_px_i,
  input  logic                            in_valid_i,
  output logic [MAX_PIXEL_BITS-1:0]       sobel_px_o,
  output logic                            sobel_valid_o,
  input  logic                            sobel_ready_i,
  output logic                            line_end_o,
  output logic                            frame_start_o,
  output logic                            frame_done_o,
  output logic                            busy_o,
  output logic                            overflow_o,
  output logic [$clog2(FIFO_DEPTH):0]     fifo_level_o
);

  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int CW    = $clog2(IMG_WIDTH);
  localparam int RW    = $clog2(IMG_HEIGHT);
  localparam int TOTAL = IMG_WIDTH * IMG_HEIGHT;
  localparam int PW    = $clog2(TOTAL + 1);

  localparam logic [CW-1:0] COL_LAST  = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST  = RW'(IMG_HEIGHT - 1);
  localparam logic [PW-1:0] PX_LAST   = PW'(TOTAL - 1);
  localparam logic [AW:0]   LEVEL_MAX = (AW + 1)'(FIFO_DEPTH);

`ifdef SOBEL_SEQ_FLUSH_EN
  localparam int FW = $clog2(FLUSH_PX + 1);
  localparam logic [FW-1:0] FLUSH_N = FW'(FLUSH_PX);
`endif

  typedef enum logic [1:0] {IDLE, STREAM, FLUSH, DONE} state_t;

  state_t state_reg, state_next;

  // FIFO storage and bookkeeping
  logic [MAX_PIXEL_BITS-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]             wr_ptr_reg, rd_ptr_reg;
  logic [AW:0]               level_reg;
  logic                      fifo_empty, fifo_full;
  logic                      push, pop, drop;

  // Issue register toward the Sobel core
  logic [MAX_PIXEL_BITS-1:0] px_reg;
  logic                      valid_reg, line_end_reg, frame_start_reg, overflow_reg;
  logic                      accept, can_load, load_zero, first_load;

  // Frame position
  logic [CW-1:0] col_reg;
  logic [RW-1:0] row_reg;
  logic [PW-1:0] px_cnt_reg;
  logic          ld_done_reg;
`ifdef SOBEL_SEQ_FLUSH_EN
  logic [FW-1:0] fl_cnt_reg;
`endif

  assign fifo_empty = (level_reg == '0);
  assign fifo_full  = (level_reg == LEVEL_MAX);
  assign accept     = valid_reg & sobel_ready_i;
  assign can_load   = ~valid_reg | accept;
  // A full FIFO still takes a pixel when its head leaves in the same cycle.
  assign push       = in_valid_i & (~fifo_full | pop);
  assign drop       = in_valid_i & fifo_full & ~pop;

  // Next-state and load decisions.
  always_comb begin
    state_next = state_reg;
    pop        = 1'b0;
    load_zero  = 1'b0;
    first_load = 1'b0;
    case (state_reg)
      IDLE: begin
        if (!fifo_empty && can_load) begin
          pop        = 1'b1;
          first_load = 1'b1;
          state_next = STREAM;
        end
      end
      STREAM: begin
        pop = ~ld_done_reg & ~fifo_empty & can_load;
        if (accept && px_cnt_reg == PX_LAST) begin
`ifdef SOBEL_SEQ_FLUSH_EN
          state_next = FLUSH;
`else
          state_next = DONE;
`endif
        end
      end
`ifdef SOBEL_SEQ_FLUSH_EN
      FLUSH: begin
        // FIFO is left untouched here: anything arriving belongs to the next frame.
        load_zero = (fl_cnt_reg != FLUSH_N) & can_load;
        if (accept && fl_cnt_reg == FLUSH_N) begin
          state_next = DONE;
        end
      end
`endif
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk_i or negedge nreset_i) begin
    if (!nreset_i) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // FIFO storage array; contents need no reset, the pointers define validity.
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem[wr_ptr_reg] <= in_px_i;
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk_i or negedge nreset_i) begin
    if (!nreset_i) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({push, pop})
        2'b10:   level_reg <= level_reg + 1'b1;
        2'b01:   level_reg <= level_reg - 1'b1;
        default: level_reg <= level_reg;
      endcase
    end
  end

  // Issue register: holds until accepted, reloads in the acceptance cycle.
  always_ff @(posedge clk_i or negedge nreset_i) begin
    if (!nreset_i) begin
      px_reg       <= '0;
      valid_reg    <= 1'b0;
      line_end_reg <= 1'b0;
    end else if (pop) begin
      px_reg       <= mem[rd_ptr_reg];
      valid_reg    <= 1'b1;
      line_end_reg <= (col_reg == COL_LAST);
    end else if (load_zero) begin
      px_reg       <= '0;
      valid_reg    <= 1'b1;
      line_end_reg <= 1'b0;
    end else if (accept) begin
      valid_reg    <= 1'b0;
      line_end_reg <= 1'b0;
    end
  end

  // Frame-start pulse and sticky overflow flag; a drop wins over the clear.
  always_ff @(posedge clk_i or negedge nreset_i) begin
    if (!nreset_i) begin
      frame_start_reg <= 1'b0;
      overflow_reg    <= 1'b0;
    end else begin
      frame_start_reg <= first_load;
      if (drop) begin
        overflow_reg <= 1'b1;
      end else if (first_load) begin
        overflow_reg <= 1'b0;
      end
    end
  end

  // Column/row/pixel position; cleared on the way back to IDLE.
  always_ff @(posedge clk_i or negedge nreset_i) begin
    if (!nreset_i) begin
      col_reg     <= '0;
      row_reg     <= '0;
      px_cnt_reg  <= '0;
      ld_done_reg <= 1'b0;
    end else if (state_reg == DONE) begin
      col_reg     <= '0;
      row_reg     <= '0;
      px_cnt_reg  <= '0;
      ld_done_reg <= 1'b0;
    end else begin
      if (pop) begin
        if (col_reg == COL_LAST) begin
          col_reg <= '0;
          row_reg <= (row_reg == ROW_LAST) ? '0 : row_reg + 1'b1;
          if (row_reg == ROW_LAST) ld_done_reg <= 1'b1;
        end else begin
          col_reg <= col_reg + 1'b1;
        end
      end
      if (accept && state_reg == STREAM) begin
        px_cnt_reg <= px_cnt_reg + 1'b1;
      end
    end
  end

`ifdef SOBEL_SEQ_FLUSH_EN
  // Count of padding pixels loaded in the current flush.
  always_ff @(posedge clk_i or negedge nreset_i) begin
    if (!nreset_i) begin
      fl_cnt_reg <= '0;
    end else if (state_reg == DONE) begin
      fl_cnt_reg <= '0;
    end else if (load_zero) begin
      fl_cnt_reg <= fl_cnt_reg + 1'b1;
    end
  end
`endif

  assign sobel_px_o    = px_reg;
  assign sobel_valid_o = valid_reg;
  assign line_end_o    = line_end_reg;
  assign frame_start_o = frame_start_reg;
  assign frame_done_o  = (state_reg == DONE);
  assign busy_o        = (state_reg != IDLE);
  assign overflow_o    = overflow_reg;
  assign fifo_level_o  = level_reg;

endmodule

// File: tb/tb_sobel_frame_sequencer.sv
// Testbench for sobel_frame_sequencer (4x3 image, 4-entry FIFO, 5 flush pixels).
// Expected pixel streams come from a frame-level model: each frame is its
// pixels in arrival order, line ends every IMG_WIDTH pixels, then padding zeros.
module tb_sobel_frame_sequencer;

  localparam int W     = 4;
  localparam int H     = 3;
  localparam int TOTAL = W * H;
`ifdef SOBEL_SEQ_FLUSH_EN
  localparam int FLUSH_N = 5;
  localparam int KEEP    = 4;   // FIFO only: issue register holds a padding zero
`else
  localparam int FLUSH_N = 0;
  localparam int KEEP    = 5;   // FIFO plus the issue register
`endif

  logic        clk = 1'b0;
  logic        nreset;
  logic [23:0] in_px;
  logic        in_valid;
  logic        sobel_ready;
  logic [23:0] sobel_px;
  logic        sobel_valid, line_end, frame_start, frame_done, busy, overflow;
  logic [2:0]  fifo_level;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [23:0] obs_px[$];
  bit          obs_le[$];
  int          obs_cyc[$];
  int          fs_cyc[$];
  bit          fs_ovf[$];
  int          fd_cyc[$];
  int          real_acc = 0;
  logic [23:0] exp_px[$];
  bit          exp_le[$];

  always #5 clk = ~clk;

  sobel_frame_sequencer #(
    .MAX_PIXEL_BITS(24), .IMG_WIDTH(W), .IMG_HEIGHT(H), .FIFO_DEPTH(4), .FLUSH_PX(5)
  ) dut (
    .clk_i(clk), .nreset_i(nreset), .in_px_i(in_px), .in_valid_i(in_valid),
    .sobel_px_o(sobel_px), .sobel_valid_o(sobel_valid), .sobel_ready_i(sobel_ready),
    .line_end_o(line_end), .frame_start_o(frame_start), .frame_done_o(frame_done),
    .busy_o(busy), .overflow_o(overflow), .fifo_level_o(fifo_level)
  );

  always @(posedge clk) cyc <= cyc + 1;

  // Transaction monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (nreset) begin
      if (sobel_valid && sobel_ready) begin
        obs_px.push_back(sobel_px);
        obs_le.push_back(line_end);
        obs_cyc.push_back(cyc);
        if (sobel_px != 0) real_acc++;
        $display("tx cycle %0d: px=%06h line_end=%0b", cyc, sobel_px, line_end);
      end
      if (frame_start) begin
        fs_cyc.push_back(cyc);
        fs_ovf.push_back(overflow);
        $display("frame_start cycle %0d overflow=%0b", cyc, overflow);
      end
      if (frame_done) begin
        fd_cyc.push_back(cyc);
        $display("frame_done cycle %0d", cyc);
      end
    end
  end

  task automatic clear_obs();
    obs_px.delete(); obs_le.delete(); obs_cyc.delete();
    fs_cyc.delete(); fs_ovf.delete(); fd_cyc.delete();
    real_acc = 0;
  endtask

  // Leaves the bench one time unit after a rising edge with reset released.
  task automatic do_reset();
    nreset = 1'b0; in_valid = 1'b0; in_px = '0; sobel_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    clear_obs();
    nreset = 1'b1;
  endtask

  // Call one time unit after a rising edge; presents a pixel for one cycle.
  task automatic strobe(input logic [23:0] v);
    in_valid = 1'b1;
    in_px    = v;
    @(posedge clk);
    #1;
  endtask

  task automatic release_in();
    in_valid = 1'b0;
  endtask

  task automatic wait_frames(input int n, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk);
      if (fd_cyc.size() >= n) begin
        ok = 1'b1;
        break;
      end
    end
    #1;
  endtask

  // Frame-level model: pixels in order, line end on every W-th, then padding.
  task automatic build_exp(input logic [23:0] pix[$]);
    exp_px.delete(); exp_le.delete();
    for (int f = 0; f < pix.size() / TOTAL; f++) begin
      for (int p = 0; p < TOTAL; p++) begin
        exp_px.push_back(pix[f * TOTAL + p]);
        exp_le.push_back((p % W) == (W - 1));
      end
      for (int z = 0; z < FLUSH_N; z++) begin
        exp_px.push_back(24'h0);
        exp_le.push_back(1'b0);
      end
    end
  endtask

  task automatic test_reset();
    nreset = 1'b0; in_valid = 1'b0; in_px = '0; sobel_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (sobel_px !== 24'h0) begin errors++; $display("FAIL reset_px: got %h expected 0", sobel_px); end
    checks++; if (sobel_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", sobel_valid); end
    checks++; if (line_end !== 1'b0) begin errors++; $display("FAIL reset_line_end: got %b expected 0", line_end); end
    checks++; if (frame_start !== 1'b0) begin errors++; $display("FAIL reset_frame_start: got %b expected 0", frame_start); end
    checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_frame_done: got %b expected 0", frame_done); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b expected 0", overflow); end
    checks++; if (fifo_level !== 3'd0) begin errors++; $display("FAIL reset_level: got %0d expected 0", fifo_level); end
    nreset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b0 || sobel_valid !== 1'b0) begin errors++; $display("FAIL idle_after_reset: got busy=%b valid=%b expected 0/0", busy, sobel_valid); end
  endtask

  task automatic test_latency();
    do_reset();
    sobel_ready = 1'b1;
    strobe(24'hABCDEF);          // cycle N
    release_in();                // now in cycle N+1
    checks++; if (sobel_valid !== 1'b0) begin errors++; $display("FAIL lat_n1_valid: got %b expected 0", sobel_valid); end
    checks++; if (fifo_level !== 3'd1) begin errors++; $display("FAIL lat_n1_level: got %0d expected 1", fifo_level); end
    @(posedge clk); #1;          // cycle N+2
    checks++; if (sobel_valid !== 1'b1 || sobel_px !== 24'hABCDEF) begin errors++; $display("FAIL lat_n2_out: got valid=%b px=%h expected 1/abcdef", sobel_valid, sobel_px); end
    checks++; if (frame_start !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL lat_n2_start: got start=%b busy=%b expected 1/1", frame_start, busy); end
    checks++; if (fifo_level !== 3'd0) begin errors++; $display("FAIL lat_n2_level: got %0d expected 0", fifo_level); end
  endtask

  task automatic test_full_frame();
    logic [23:0] pix[$];
    bit ok;
    do_reset();
    sobel_ready = 1'b1;
    for (int i = 0; i < TOTAL; i++) pix.push_back(24'($urandom_range(1, 24'hFFFFFF)));
    for (int i = 0; i < TOTAL; i++) strobe(pix[i]);
    release_in();
    wait_frames(1, 200, ok);
    checks++; if (!ok) begin errors++; $display("FAIL frame_timeout: got no frame_done expected one"); end
    build_exp(pix);
    checks++; if (obs_px.size() != exp_px.size()) begin errors++; $display("FAIL frame_len: got %0d expected %0d", obs_px.size(), exp_px.size()); end
    for (int i = 0; i < exp_px.size() && i < obs_px.size(); i++) begin
      checks++;
      if (obs_px[i] !== exp_px[i] || obs_le[i] !== exp_le[i]) begin
        errors++; $display("FAIL frame_px[%0d]: got %h/%0b expected %h/%0b", i, obs_px[i], obs_le[i], exp_px[i], exp_le[i]);
      end
    end
    checks++; if (fs_cyc.size() != 1 || fd_cyc.size() != 1) begin errors++; $display("FAIL frame_pulses: got start=%0d done=%0d expected 1/1", fs_cyc.size(), fd_cyc.size()); end
    if (fs_cyc.size() > 0 && fd_cyc.size() > 0 && obs_cyc.size() > 0) begin
      checks++; if (fs_cyc[0] != obs_cyc[0]) begin errors++; $display("FAIL frame_start_cycle: got %0d expected %0d", fs_cyc[0], obs_cyc[0]); end
      checks++; if (fd_cyc[0] != obs_cyc[obs_cyc.size() - 1] + 1) begin errors++; $display("FAIL frame_done_cycle: got %0d expected %0d", fd_cyc[0], obs_cyc[obs_cyc.size() - 1] + 1); end
    end
  endtask

  task automatic test_overflow();
    logic [23:0] pix[$];
    logic [23:0] sent[$];
    bit ok;
    do_reset();
    sobel_ready = 1'b0;
    for (int i = 0; i < TOTAL + 1; i++) sent.push_back(24'($urandom_range(1, 24'hFFFFFF)));
    for (int i = 0; i < 5; i++) strobe(sent[i]);
    release_in();
    repeat (2) @(posedge clk); #1;
    checks++; if (fifo_level !== 3'd4) begin errors++; $display("FAIL ovf_level: got %0d expected 4", fifo_level); end
    checks++; if (sobel_valid !== 1'b1 || sobel_px !== sent[0]) begin errors++; $display("FAIL ovf_held: got valid=%b px=%h expected 1/%h", sobel_valid, sobel_px, sent[0]); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_early: got %b expected 0", overflow); end
    strobe(sent[5]);             // dropped
    release_in();
    checks++; if (overflow !== 1'b1 || fifo_level !== 3'd4) begin errors++; $display("FAIL ovf_set: got ovf=%b level=%0d expected 1/4", overflow, fifo_level); end
    sobel_ready = 1'b1;
    repeat (2) @(posedge clk); #1;
    for (int i = 6; i < TOTAL + 1; i++) strobe(sent[i]);
    release_in();
    wait_frames(1, 200, ok);
    checks++; if (!ok) begin errors++; $display("FAIL ovf_timeout: got no frame_done expected one"); end
    for (int i = 0; i < TOTAL + 1; i++) if (i != 5) pix.push_back(sent[i]);
    build_exp(pix);
    checks++; if (obs_px.size() != exp_px.size()) begin errors++; $display("FAIL ovf_len: got %0d expected %0d", obs_px.size(), exp_px.size()); end
    for (int i = 0; i < exp_px.size() && i < obs_px.size(); i++) begin
      checks++;
      if (obs_px[i] !== exp_px[i] || obs_le[i] !== exp_le[i]) begin
        errors++; $display("FAIL ovf_px[%0d]: got %h/%0b expected %h/%0b", i, obs_px[i], obs_le[i], exp_px[i], exp_le[i]);
      end
    end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %b expected 1", overflow); end
  endtask

  task automatic test_flush_arrivals();
    logic [23:0] pix[$];
    logic [23:0] q[$];
    bit ok;
    do_reset();
    sobel_ready = 1'b1;
    for (int i = 0; i < TOTAL; i++) pix.push_back(24'($urandom_range(1, 24'hFFFFFF)));
    for (int i = 0; i < TOTAL; i++) strobe(pix[i]);
    release_in();
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk);
      if (obs_px.size() >= TOTAL) begin ok = 1'b1; break; end
    end
    #1;
    checks++; if (!ok) begin errors++; $display("FAIL fa_timeout1: got %0d pixels expected %0d", obs_px.size(), TOTAL); end
    sobel_ready = 1'b0;
    for (int i = 0; i < TOTAL + 1; i++) q.push_back(24'($urandom_range(1, 24'hFFFFFF)));
    for (int i = 0; i <= KEEP; i++) strobe(q[i]);   // last one dropped
    release_in();
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL fa_overflow: got %b expected 1", overflow); end
    sobel_ready = 1'b1;
    wait_frames(1, 200, ok);
    repeat (8) @(posedge clk); #1;
    for (int i = KEEP + 1; i < TOTAL + 1; i++) strobe(q[i]);
    release_in();
    wait_frames(2, 300, ok);
    checks++; if (!ok) begin errors++; $display("FAIL fa_timeout2: got %0d frame_done expected 2", fd_cyc.size()); end
    for (int i = 0; i < TOTAL + 1; i++) if (i != KEEP) pix.push_back(q[i]);
    build_exp(pix);
    checks++; if (obs_px.size() != exp_px.size()) begin errors++; $display("FAIL fa_len: got %0d expected %0d", obs_px.size(), exp_px.size()); end
    for (int i = 0; i < exp_px.size() && i < obs_px.size(); i++) begin
      checks++;
      if (obs_px[i] !== exp_px[i] || obs_le[i] !== exp_le[i]) begin
        errors++; $display("FAIL fa_px[%0d]: got %h/%0b expected %h/%0b", i, obs_px[i], obs_le[i], exp_px[i], exp_le[i]);
      end
    end
    checks++; if (fs_cyc.size() != 2 || fd_cyc.size() != 2) begin errors++; $display("FAIL fa_pulses: got start=%0d done=%0d expected 2/2", fs_cyc.size(), fd_cyc.size()); end
    if (fs_cyc.size() == 2 && fd_cyc.size() == 2) begin
      checks++; if (fs_cyc[1] < fd_cyc[0] + 2) begin errors++; $display("FAIL fa_start_gap: got start %0d expected >= %0d", fs_cyc[1], fd_cyc[0] + 2); end
      checks++; if (fs_ovf[1] !== 1'b0) begin errors++; $display("FAIL fa_ovf_clear: got %b expected 0", fs_ovf[1]); end
    end
  endtask

  task automatic test_reset_midframe();
    logic [23:0] pix[$];
    bit ok;
    do_reset();
    sobel_ready = 1'b1;
    for (int i = 0; i < 7; i++) strobe(24'($urandom_range(1, 24'hFFFFFF)));
    release_in();
    @(posedge clk); #3;
    nreset = 1'b0;
    #1;
    checks++; if (sobel_valid !== 1'b0 || sobel_px !== 24'h0 || line_end !== 1'b0) begin errors++; $display("FAIL mid_out: got valid=%b px=%h le=%b expected 0/0/0", sobel_valid, sobel_px, line_end); end
    checks++; if (busy !== 1'b0 || frame_start !== 1'b0 || frame_done !== 1'b0) begin errors++; $display("FAIL mid_flags: got busy=%b fs=%b fd=%b expected 0/0/0", busy, frame_start, frame_done); end
    checks++; if (fifo_level !== 3'd0 || overflow !== 1'b0) begin errors++; $display("FAIL mid_fifo: got level=%0d ovf=%b expected 0/0", fifo_level, overflow); end
    @(posedge clk); #1;
    clear_obs();
    nreset = 1'b1;
    for (int i = 0; i < TOTAL; i++) pix.push_back(24'($urandom_range(1, 24'hFFFFFF)));
    for (int i = 0; i < TOTAL; i++) strobe(pix[i]);
    release_in();
    wait_frames(1, 200, ok);
    checks++; if (!ok) begin errors++; $display("FAIL mid_timeout: got no frame_done expected one"); end
    build_exp(pix);
    checks++; if (obs_px.size() != exp_px.size()) begin errors++; $display("FAIL mid_len: got %0d expected %0d", obs_px.size(), exp_px.size()); end
    for (int i = 0; i < exp_px.size() && i < obs_px.size(); i++) begin
      checks++;
      if (obs_px[i] !== exp_px[i] || obs_le[i] !== exp_le[i]) begin
        errors++; $display("FAIL mid_px[%0d]: got %h/%0b expected %h/%0b", i, obs_px[i], obs_le[i], exp_px[i], exp_le[i]);
      end
    end
    checks++; if (fs_cyc.size() != 1) begin errors++; $display("FAIL mid_start: got %0d frame_start expected 1", fs_cyc.size()); end
  endtask

  task automatic test_random_frames();
    logic [23:0] pix[$];
    int sent;
    bit ok;
    do_reset();
    for (int i = 0; i < 3 * TOTAL; i++) pix.push_back(24'($urandom_range(1, 24'hFFFFFF)));
    sent = 0;
    ok = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      sobel_ready = ($urandom_range(0, 3) != 0);
      if (sent < pix.size() && (sent - real_acc) < 3 && $urandom_range(0, 1) == 1) begin
        in_valid = 1'b1; in_px = pix[sent]; sent++;
      end else begin
        in_valid = 1'b0;
      end
      @(posedge clk); #1;
      if (fd_cyc.size() >= 3) begin ok = 1'b1; break; end
    end
    release_in();
    sobel_ready = 1'b1;
    checks++; if (!ok) begin errors++; $display("FAIL rnd_timeout: got %0d frame_done expected 3", fd_cyc.size()); end
    build_exp(pix);
    checks++; if (obs_px.size() != exp_px.size()) begin errors++; $display("FAIL rnd_len: got %0d expected %0d", obs_px.size(), exp_px.size()); end
    for (int i = 0; i < exp_px.size() && i < obs_px.size(); i++) begin
      checks++;
      if (obs_px[i] !== exp_px[i] || obs_le[i] !== exp_le[i]) begin
        errors++; $display("FAIL rnd_px[%0d]: got %h/%0b expected %h/%0b", i, obs_px[i], obs_le[i], exp_px[i], exp_le[i]);
      end
    end
    checks++; if (fs_cyc.size() != 3 || fd_cyc.size() != 3) begin errors++; $display("FAIL rnd_pulses: got start=%0d done=%0d expected 3/3", fs_cyc.size(), fd_cyc.size()); end
    for (int k = 1; k < fs_cyc.size() && k <= fd_cyc.size(); k++) begin
      checks++; if (fs_cyc[k] < fd_cyc[k - 1] + 2) begin errors++; $display("FAIL rnd_gap[%0d]: got start %0d expected >= %0d", k, fs_cyc[k], fd_cyc[k - 1] + 2); end
    end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL rnd_overflow: got %b expected 0", overflow); end
  endtask

  initial begin
    nreset = 1'b0; in_valid = 1'b0; in_px = '0; sobel_ready = 1'b0;
    test_reset();
    test_latency();
    test_full_frame();
    test_overflow();
    test_flush_arrivals();
    test_reset_midframe();
    test_random_frames();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no completion expected finish before 2ms");
    $fatal(1, "watchdog expired");
  end

endmodule
